// File: rtl/ime_pkg.sv
// Shared types and constants for the frame arbiter.
package ime_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_ABORT = 2'd2
    } ime_state_e;

    // m_tuser bit that marks a watchdog-aborted (poisoned) frame end
    localparam int TUSER_POISON_BIT = 2;
endpackage

// File: rtl/ime_rr_pick.sv
// Round-robin search: first requester strictly after 'last', wrapping.
module ime_rr_pick #(
    parameter int N_SRC = 4,
    parameter int GW    = $clog2(N_SRC)
) (
    input  logic [N_SRC-1:0] req,
    input  logic [GW-1:0]    last,
    output logic [GW-1:0]    grant,
    output logic             any
);
    int idx;

    // Walk from farthest to nearest so the nearest hit wins; k == N_SRC is 'last' itself.
    always_comb begin
        grant = last;
        any   = 1'b0;
        idx   = 0;
        for (int k = N_SRC; k >= 1; k--) begin
            idx = (int'(last) + k) % N_SRC;
            if (req[idx]) begin
                grant = GW'(idx);
                any   = 1'b1;
            end
        end
    end
endmodule

// File: rtl/ime_frame_arb.sv
// Frame-granular round-robin merge of N_SRC streams with beat limit and idle watchdog.
module ime_frame_arb
    import ime_pkg::*;
#(
    parameter int N_SRC   = 4,
    parameter int W_DATA  = 48,
    parameter int TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [N_SRC*W_DATA-1:0]   s_tdata,
    input  logic [N_SRC*8-1:0]        s_tuser,
    input  logic [N_SRC-1:0]          s_tvalid,
    input  logic [N_SRC-1:0]          s_tlast,
    output logic [N_SRC-1:0]          s_tready,
    output logic [W_DATA-1:0]         m_tdata,
    output logic [7:0]                m_tuser,
    output logic                      m_tvalid,
    output logic                      m_tlast,
    input  logic                      m_tready,
    input  logic [N_SRC-1:0]          src_enable,
    input  logic [15:0]               frame_len,
    output logic [$clog2(N_SRC)-1:0]  grant_id,
    output logic                      busy,
    output logic                      timeout_evt
);
    localparam int GW = $clog2(N_SRC);

    ime_state_e        state;
    logic [15:0]       beat_cnt;
    logic [15:0]       idle_cnt;
    logic [15:0]       flen_q;
    logic [N_SRC-1:0]  req;
    logic [GW-1:0]     pick;
    logic              any_req;
    logic [W_DATA-1:0] sel_data;
    logic [4:0]        sel_user_hi;
    logic              sel_valid;
    logic              sel_last;
    logic              force_end;
    logic [1:0]        g2;

    assign req = s_tvalid & src_enable;

    ime_rr_pick #(.N_SRC(N_SRC), .GW(GW)) u_pick (
        .req   (req),
        .last  (grant_id),
        .grant (pick),
        .any   (any_req)
    );

    assign sel_data    = s_tdata[int'(grant_id)*W_DATA +: W_DATA];
    assign sel_user_hi = s_tuser[int'(grant_id)*8 + 3 +: 5];
    assign sel_valid   = s_tvalid[grant_id];
    assign sel_last    = s_tlast[grant_id];
    assign g2          = 2'(grant_id);
    assign force_end   = (flen_q != 16'd0) && (beat_cnt + 16'd1 == flen_q);

    always_comb begin
        s_tready = '0;
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;
        m_tdata  = '0;
        m_tuser  = '0;
        case (state)
            ST_XFER: begin
                m_tvalid           = sel_valid;
                m_tlast            = sel_last | force_end;
                m_tdata            = sel_data;
                m_tuser            = {sel_user_hi, 1'b0, g2};
                s_tready[grant_id] = m_tready;
            end
            ST_ABORT: begin
                m_tvalid                  = 1'b1;
                m_tlast                   = 1'b1;
                m_tuser[1:0]              = g2;
                m_tuser[TUSER_POISON_BIT] = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            grant_id    <= GW'(N_SRC - 1);
            beat_cnt    <= '0;
            idle_cnt    <= '0;
            flen_q      <= '0;
            busy        <= 1'b0;
            timeout_evt <= 1'b0;
        end else begin
            timeout_evt <= 1'b0;
            case (state)
                ST_IDLE: if (any_req) begin
                    // frame_len is captured here so a mid-frame CSR write cannot reshape this frame
                    grant_id <= pick;
                    flen_q   <= frame_len;
                    beat_cnt <= '0;
                    idle_cnt <= '0;
                    busy     <= 1'b1;
                    state    <= ST_XFER;
                end
                ST_XFER: begin
                    if (!sel_valid) begin
                        if (idle_cnt + 16'd1 == 16'(TIMEOUT)) begin
                            state    <= ST_ABORT;
                            beat_cnt <= '0;
                            idle_cnt <= '0;
                        end else begin
                            idle_cnt <= idle_cnt + 16'd1;
                        end
                    end else begin
                        idle_cnt <= '0;
                        if (m_tready) begin
                            if (sel_last | force_end) begin
                                state    <= ST_IDLE;
                                busy     <= 1'b0;
                                beat_cnt <= '0;
                            end else begin
                                beat_cnt <= beat_cnt + 16'd1;
                            end
                        end
                    end
                end
                ST_ABORT: if (m_tready) begin
                    // event is registered, so it is seen in the cycle after the poison beat
                    timeout_evt <= 1'b1;
                    busy        <= 1'b0;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ime_frame_arb.sv
// Directed bench for ime_frame_arb: per-cycle reference model plus literal scenario checks.
module tb_ime_frame_arb;
    localparam int N  = 4;
    localparam int W  = 48;
    localparam int TO = 8;

    typedef struct packed { logic [W-1:0] data; logic [7:0] user; logic last; } beat_t;
    typedef struct packed { logic [W-1:0] data; logic [7:0] user; logic last; logic [31:0] cyc; } obs_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N*W-1:0]  s_tdata;
    logic [N*8-1:0]  s_tuser;
    logic [N-1:0]    s_tvalid, s_tlast, s_tready;
    logic [W-1:0]    m_tdata;
    logic [7:0]      m_tuser;
    logic            m_tvalid, m_tlast, m_tready;
    logic [N-1:0]    src_enable;
    logic [15:0]     frame_len;
    logic [1:0]      grant_id;
    logic            busy, timeout_evt;

    always #5 clk = ~clk;

    ime_frame_arb #(.N_SRC(N), .W_DATA(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_tdata(s_tdata), .s_tuser(s_tuser), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
        .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tuser(m_tuser), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
        .m_tready(m_tready),
        .src_enable(src_enable), .frame_len(frame_len),
        .grant_id(grant_id), .busy(busy), .timeout_evt(timeout_evt)
    );

    int       errors = 0;
    int       checks = 0;
    int       cyc = 0;
    int       evt_cnt = 0;
    bit       model_on = 0;
    beat_t    srcq[N][$];
    obs_t     log_q[$];
    logic [N-1:0] hs_q = '0;

    // reference model: mode 0 idle, 1 streaming from mlast, 2 emitting poison beat
    int md = 0, mlast = N-1, nb = 0, starve = 0, flen = 0;
    bit mevt = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        logic [W-1:0] ed;
        logic [7:0]   eu;
        logic         ev, el;
        logic [N-1:0] er;
        logic [N-1:0] rq;
        bit           nevt, found;
        cyc++;
        ev = 0; el = 0; ed = '0; eu = '0; er = '0;
        if (md == 1) begin
            ev = s_tvalid[mlast];
            ed = s_tdata[mlast*W +: W];
            el = s_tlast[mlast] || (flen != 0 && nb + 1 == flen);
            eu = (s_tuser[mlast*8 +: 8] & 8'hF8) | 8'(mlast);
            er[mlast] = m_tready;
        end else if (md == 2) begin
            ev = 1; el = 1; eu = 8'h04 | 8'(mlast);
        end
        if (model_on) begin
            chk("busy", 64'(busy), 64'(md != 0));
            chk("m_tvalid", 64'(m_tvalid), 64'(ev));
            chk("s_tready", 64'(s_tready), 64'(er));
            chk("grant_id", 64'(grant_id), 64'(mlast));
            chk("timeout_evt", 64'(timeout_evt), 64'(mevt));
            if (ev) begin
                chk("m_tdata", 64'(m_tdata), 64'(ed));
                chk("m_tuser", 64'(m_tuser), 64'(eu));
                chk("m_tlast", 64'(m_tlast), 64'(el));
            end
        end
        hs_q = s_tvalid & s_tready;
        if (model_on && m_tvalid && m_tready) log_q.push_back({m_tdata, m_tuser, m_tlast, 32'(cyc)});
        if (timeout_evt) evt_cnt++;

        nevt = 0;
        if (!rst_n) begin
            md = 0; mlast = N-1; nb = 0; starve = 0;
        end else if (md == 0) begin
            rq = s_tvalid & src_enable;
            found = 0;
            for (int off = 1; off <= N; off++)
                if (!found && rq[(mlast + off) % N]) begin
                    found = 1; mlast = (mlast + off) % N;
                end
            if (found) begin md = 1; nb = 0; starve = 0; flen = int'(frame_len); end
        end else if (md == 1) begin
            if (s_tvalid[mlast]) begin
                starve = 0;
                if (m_tready) begin
                    if (s_tlast[mlast] || (flen != 0 && nb + 1 == flen)) md = 0;
                    else nb++;
                end
            end else begin
                starve++;
                if (starve == TO) begin md = 2; starve = 0; end
            end
        end else if (m_tready) begin
            nevt = 1; md = 0;
        end
        mevt = nevt;
    end

    // sources: present queue heads, retire a head after its handshake edge
    always @(posedge clk) begin
        #2;
        for (int i = 0; i < N; i++)
            if (hs_q[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
        for (int i = 0; i < N; i++) begin
            if (srcq[i].size() > 0) begin
                s_tvalid[i]       = 1'b1;
                s_tdata[i*W +: W] = srcq[i][0].data;
                s_tuser[i*8 +: 8] = srcq[i][0].user;
                s_tlast[i]        = srcq[i][0].last;
            end else begin
                s_tvalid[i]       = 1'b0;
                s_tdata[i*W +: W] = '0;
                s_tuser[i*8 +: 8] = '0;
                s_tlast[i]        = 1'b0;
            end
        end
    end

    task automatic push(int s, int n, int base, bit last_end);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b.data = W'(base + k);
            b.user = {5'(base + k + s), 3'b111};
            b.last = last_end && (k == n - 1);
            srcq[s].push_back(b);
        end
    endtask

    task automatic tick(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_done(int max, string nm);
        int  t;
        bit  done;
        t = 0; done = 0;
        while (!done && t < max) begin
            tick(1); t++;
            done = (busy == 1'b0);
            for (int i = 0; i < N; i++) if (srcq[i].size() != 0) done = 0;
        end
        chk({nm, "_done"}, 64'(done), 64'(1));
    endtask

    task automatic wait_log(int n, int max, string nm);
        int t;
        t = 0;
        while (log_q.size() < n && t < max) begin tick(1); t++; end
        chk({nm, "_log"}, 64'(log_q.size() >= n), 64'(1));
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int exp_b[5];
        exp_b = '{0, 1, 2, 3, 0};
        rst_n = 0; m_tready = 1; src_enable = 4'hF; frame_len = 16'd0;
        s_tvalid = '0; s_tlast = '0; s_tdata = '0; s_tuser = '0;
        tick(2);
        rst_n = 1; model_on = 1;
        @(negedge clk);
        chk("rst_grant_id", 64'(grant_id), 64'(3));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_m_tvalid", 64'(m_tvalid), 64'(0));
        chk("rst_s_tready", 64'(s_tready), 64'(0));
        chk("rst_timeout_evt", 64'(timeout_evt), 64'(0));
        tick(1);

        // two simultaneous 3-beat frames
        log_q.delete();
        push(0, 3, 'h100, 1); push(2, 3, 'h200, 1);
        wait_done(100, "a");
        chk("a_beats", 64'(log_q.size()), 64'(6));
        if (log_q.size() == 6) begin
            for (int k = 0; k < 3; k++) begin
                chk("a_src0_id", 64'(log_q[k].user[1:0]), 64'(0));
                chk("a_src0_data", 64'(log_q[k].data), 64'('h100 + k));
                chk("a_src2_id", 64'(log_q[k+3].user[1:0]), 64'(2));
                chk("a_src2_data", 64'(log_q[k+3].data), 64'('h200 + k));
            end
            chk("a_last", 64'(log_q[2].last), 64'(1));
            chk("a_bubble", 64'(log_q[3].cyc - log_q[2].cyc), 64'(2));
        end

        // reset so the rotation starts at source 0, then all sources hammer 1-beat frames
        rst_n = 0; tick(1); rst_n = 1;
        log_q.delete();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N; i++) push(i, 1, 'h300 + 16*i + r, 1);
        wait_done(100, "b");
        chk("b_beats", 64'(log_q.size()), 64'(8));
        if (log_q.size() == 8)
            for (int k = 0; k < 5; k++) chk("b_rr_order", 64'(log_q[k].user[1:0]), 64'(exp_b[k]));

        // beat-limited frames of 4
        frame_len = 16'd4;
        log_q.delete();
        push(1, 10, 'h400, 1);
        wait_done(200, "c");
        frame_len = 16'd0;
        chk("c_beats", 64'(log_q.size()), 64'(10));
        if (log_q.size() == 10)
            for (int k = 0; k < 10; k++) begin
                chk("c_tlast", 64'(log_q[k].last), 64'(k == 3 || k == 7 || k == 9));
                chk("c_data", 64'(log_q[k].data), 64'('h400 + k));
            end

        // stalled source triggers watchdog abort
        log_q.delete(); evt_cnt = 0;
        push(3, 2, 'h500, 0);
        wait_done(100, "d");
        tick(2);
        chk("d_beats", 64'(log_q.size()), 64'(3));
        if (log_q.size() == 3) begin
            chk("d_poison_data", 64'(log_q[2].data), 64'(0));
            chk("d_poison_user", 64'(log_q[2].user), 64'('h07));
            chk("d_poison_last", 64'(log_q[2].last), 64'(1));
            chk("d_idle_gap", 64'(log_q[2].cyc - log_q[1].cyc), 64'(9));
        end
        chk("d_evt_pulses", 64'(evt_cnt), 64'(1));
        log_q.delete();
        push(0, 1, 'h600, 1);
        wait_done(50, "d2");
        chk("d2_beats", 64'(log_q.size()), 64'(1));
        if (log_q.size() == 1) begin
            chk("d2_user_lo", 64'(log_q[0].user[2:0]), 64'(0));
            chk("d2_data", 64'(log_q[0].data), 64'('h600));
        end

        // long backpressure with valid source must not abort
        log_q.delete(); evt_cnt = 0;
        push(2, 6, 'h700, 1);
        wait_log(2, 50, "e");
        m_tready = 0;
        tick(300);
        m_tready = 1;
        wait_done(100, "e");
        tick(2);
        chk("e_evt_pulses", 64'(evt_cnt), 64'(0));
        chk("e_beats", 64'(log_q.size()), 64'(6));
        if (log_q.size() == 6)
            for (int k = 0; k < 6; k++) chk("e_data", 64'(log_q[k].data), 64'('h700 + k));

        // reset during beat 2 of a frame
        src_enable = 4'b1010;
        log_q.delete();
        push(1, 5, 'h800, 1); push(3, 5, 'h900, 1);
        wait_log(1, 50, "f");
        chk("f_pre_id", 64'(log_q[0].user[1:0]), 64'(3));
        rst_n = 0; tick(1); rst_n = 1;
        log_q.delete();
        @(negedge clk);
        chk("f_rst_m_tvalid", 64'(m_tvalid), 64'(0));
        chk("f_rst_s_tready", 64'(s_tready), 64'(0));
        chk("f_rst_busy", 64'(busy), 64'(0));
        tick(1);
        wait_done(200, "f");
        chk("f_first_id", 64'(log_q.size() > 0 ? log_q[0].user[1:0] : 2'd0), 64'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
